// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_pkg;

    // Largest legal image, in 32-bit words.
    localparam int unsigned IMEM_DEPTH = 1024;
    // Width of the little-endian word-count header.
    localparam int unsigned IMEM_HDR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CSUM,
        FINISH
    } imem_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and strobes
// o_word_valid for one cycle after the 4th byte of each word.
module byte_word_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_lane_last,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_word_valid;

    // High while the byte being accepted now completes a word.
    assign o_lane_last  = i_byte_valid && (r_cnt == 2'd3);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    // Lane register: byte k lands in bits [8k+7:8k]; the counter wraps after lane 3.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= o_lane_last;
            if (i_byte_valid) begin
                r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
                r_cnt                       <= r_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: header (word count N), 4N data
// bytes packed into words, optional trailing XOR checksum byte.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic                  o_mem_we,
    output logic [31:0]           o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [IMEM_HDR_W-1:0] o_words_loaded
);

    imem_state_t           r_state, w_next;
    logic                  r_rx_ready, r_busy, r_hold, r_done, r_err;
    logic [31:0]           r_mem_addr;
    logic [IMEM_HDR_W-1:0] r_n, r_words_loaded, w_hdr_n;
    logic                  w_fire, w_hdr_bad, w_byte_in, w_lane_last;
    logic                  w_last_word, w_pack_clear, w_word_valid, w_rdy_next;
    logic [31:0]           w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_xor;
    logic                  w_csum_ok;
`endif

    assign w_fire       = i_rx_valid && r_rx_ready;
    assign w_hdr_n      = {i_rx_data, r_n[7:0]};
    assign w_hdr_bad    = (w_hdr_n == '0) || (32'(w_hdr_n) > DEPTH);
    assign w_byte_in    = (r_state == DATA) && w_fire;
    assign w_pack_clear = (r_state == IDLE) && i_start;
    assign w_last_word  = w_lane_last && ((r_words_loaded + 16'd1) == r_n);
    assign w_rdy_next   = (w_next == HDR0) || (w_next == HDR1) ||
                          (w_next == DATA) || (w_next == CSUM);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_csum_ok    = (i_rx_data == r_xor);
`endif

    byte_word_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_pack_clear),
        .i_byte_valid (w_byte_in),
        .i_byte       (i_rx_data),
        .o_lane_last  (w_lane_last),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (i_start) w_next = HDR0;
            HDR0:   if (w_fire)  w_next = HDR1;
            HDR1:   if (w_fire)  w_next = w_hdr_bad ? IDLE : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            DATA:   if (w_last_word) w_next = CSUM;
            CSUM:   if (w_fire)  w_next = w_csum_ok ? FINISH : IDLE;
`else
            DATA:   if (w_last_word) w_next = FINISH;
`endif
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status, header, address and word-count registers. Completion flags are
    // set on the transition into FINISH so they coincide with the last strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_ready     <= 1'b0;
            r_busy         <= 1'b0;
            r_hold         <= 1'b1;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_mem_addr     <= '0;
            r_n            <= '0;
            r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor          <= '0;
`endif
        end else begin
            r_rx_ready <= w_rdy_next;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_busy         <= 1'b1;
                    r_hold         <= 1'b1;
                    r_err          <= 1'b0;
                    r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_xor          <= '0;
`endif
                end
                HDR0: if (w_fire) r_n <= {8'h00, i_rx_data};
                HDR1: if (w_fire) begin
                    if (w_hdr_bad) begin
                        r_err  <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_n <= w_hdr_n;
                    end
                end
                DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_byte_in) r_xor <= r_xor ^ i_rx_data;
`endif
                    if (w_lane_last) begin
                        r_words_loaded <= r_words_loaded + 16'd1;
                        r_mem_addr     <= {{(30-IMEM_HDR_W){1'b0}}, r_words_loaded, 2'b00};
                    end
`ifndef IMEM_LOADER_CHECKSUM_EN
                    if (w_last_word) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_hold <= 1'b0;
                    end
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: if (w_fire) begin
                    r_busy <= 1'b0;
                    if (w_csum_ok) begin
                        r_done <= 1'b1;
                        r_hold <= 1'b0;
                    end else begin
                        r_err  <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_rx_ready     = r_rx_ready;
    assign o_mem_we       = w_word_valid;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wdata    = w_word;
    assign o_cpu_hold     = r_hold;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Honours IMEM_LOADER_CHECKSUM_EN in step with the design.
module tb_imem_loader;
    import imem_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready, o_mem_we, o_cpu_hold, o_busy, o_done, o_err;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [15:0] o_words_loaded;

    always #5 i_clk = ~i_clk;

    imem_loader #(.DEPTH(IMEM_DEPTH)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_rx_ready     (o_rx_ready),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_cpu_hold     (o_cpu_hold),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_words_loaded (o_words_loaded)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    wr_t         sb_q[$];
    wr_t         mon_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_we     = 0;
    int unsigned n_done   = 0;
    logic        prev_we  = 1'b0;
    logic [31:0] img [0:3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (o_done === 1'b1) n_done++;
        if (o_mem_we === 1'b1) begin
            n_we++;
            chk("we_back_to_back", {31'b0, prev_we}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {31'b0, o_mem_we}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_addr", o_mem_addr, mon_e.addr);
                chk("wr_data", o_mem_wdata, mon_e.data);
`ifndef IMEM_LOADER_CHECKSUM_EN
                chk("done_with_last_we", {31'b0, o_done}, {31'b0, mon_e.last});
`endif
            end
        end
        prev_we = o_mem_we;
    end

    // Present a byte until accepted; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned k;
        repeat (gap) @(negedge i_clk);
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        k = 0;
        while (o_rx_ready !== 1'b1 && k < 64) begin
            @(negedge i_clk);
            k++;
        end
        if (k == 64) begin
            chk("rx_ready_timeout", {31'b0, o_rx_ready}, 32'd1);
            i_rx_valid = 1'b0;
        end else begin
            @(posedge i_clk);
            #1;
            i_rx_valid = 1'b0;
        end
    endtask

    task automatic start_pulse();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Start, header, and all data bytes of img[0..n-1]; returns the data XOR.
    task automatic load_body(input int unsigned n, input int unsigned gap,
                             input bit mid_start, output logic [7:0] x);
        logic [7:0]  b;
        logic [15:0] hn;
        x  = '0;
        hn = n[15:0];
        repeat (2) @(negedge i_clk);
        start_pulse();
        chk("start_busy", {31'b0, o_busy}, 32'd1);
        chk("start_err_clr", {31'b0, o_err}, 32'd0);
        chk("start_wl_clr", {16'b0, o_words_loaded}, 32'd0);
        send_byte(hn[7:0], gap);
        send_byte(hn[15:8], gap);
        for (int unsigned w = 0; w < n; w++) begin
            sb_q.push_back('{addr: w * 4, data: img[w], last: (w == n - 1)});
            for (int unsigned k = 0; k < 4; k++) begin
                b = img[w][8*k +: 8];
                x = x ^ b;
                send_byte(b, gap);
            end
            if (mid_start && w == 0) begin
                start_pulse();
                chk("mid_start_busy", {31'b0, o_busy}, 32'd1);
                chk("mid_start_wl", {16'b0, o_words_loaded}, 32'd1);
            end
        end
    endtask

    // Completion checks for a good image (n words).
    task automatic finish_good(input logic [7:0] x, input int unsigned n);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`else
        chk("final_we", {31'b0, o_mem_we}, {31'b0, (x == x)});
`endif
        chk("done_pulse", {31'b0, o_done}, 32'd1);
        chk("done_hold", {31'b0, o_cpu_hold}, 32'd0);
        chk("done_busy", {31'b0, o_busy}, 32'd0);
        chk("done_wl", {16'b0, o_words_loaded}, n);
    endtask

    initial begin
        logic [7:0]  x;
        int unsigned we0, d0;
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  x;
        int unsigned we0, d0;

        // Reset
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rst_hold", {31'b0, o_cpu_hold}, 32'd1);
        chk("rst_ready", {31'b0, o_rx_ready}, 32'd0);
        chk("rst_we", {31'b0, o_mem_we}, 32'd0);
        chk("rst_wl", {16'b0, o_words_loaded}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        i_rst = 1'b0;

        // Two-word load
        img[0] = 32'h00500013;
        img[1] = 32'h00100093;
        we0 = n_we; d0 = n_done;
        load_body(2, 0, 1'b0, x);
        finish_good(x, 2);
        repeat (3) @(negedge i_clk);
        chk("two_word_we_count", n_we - we0, 32'd2);
        chk("two_word_done_count", n_done - d0, 32'd1);

        // Invalid counts: N=0 then N=1025
        we0 = n_we;
        repeat (2) @(negedge i_clk);
        start_pulse();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("n0_err", {31'b0, o_err}, 32'd1);
        chk("n0_busy", {31'b0, o_busy}, 32'd0);
        chk("n0_hold", {31'b0, o_cpu_hold}, 32'd1);
        chk("n0_ready", {31'b0, o_rx_ready}, 32'd0);
        repeat (2) @(negedge i_clk);
        start_pulse();
        chk("restart_err_clr", {31'b0, o_err}, 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        chk("n1025_err", {31'b0, o_err}, 32'd1);
        chk("n1025_busy", {31'b0, o_busy}, 32'd0);
        chk("n1025_hold", {31'b0, o_cpu_hold}, 32'd1);
        repeat (3) @(negedge i_clk);
        chk("invalid_no_we", n_we - we0, 32'd0);
        chk("invalid_err_sticky", {31'b0, o_err}, 32'd1);

        // Backpressure, 3 words, start pulsed mid-load
        img[0] = 32'hA1B2C3D4;
        img[1] = 32'h0000FFFF;
        img[2] = 32'h12345678;
        we0 = n_we; d0 = n_done;
        load_body(3, 1, 1'b1, x);
        finish_good(x, 3);
        repeat (3) @(negedge i_clk);
        chk("bp_we_count", n_we - we0, 32'd3);
        chk("bp_done_count", n_done - d0, 32'd1);

        // Reset after 6 data bytes of a 2-word load
        img[0] = 32'h04030201;
        repeat (2) @(negedge i_clk);
        start_pulse();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        sb_q.push_back('{addr: 32'h0, data: img[0], last: 1'b0});
        for (int unsigned k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("midrst_wl", {16'b0, o_words_loaded}, 32'd0);
        chk("midrst_hold", {31'b0, o_cpu_hold}, 32'd1);
        chk("midrst_busy", {31'b0, o_busy}, 32'd0);
        chk("midrst_ready", {31'b0, o_rx_ready}, 32'd0);
        img[0] = 32'hDEADBEEF;
        we0 = n_we;
        load_body(1, 0, 1'b0, x);
        finish_good(x, 1);
        repeat (3) @(negedge i_clk);
        chk("after_rst_we_count", n_we - we0, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match then mismatch
        img[0] = 32'h44332211;
        load_body(1, 0, 1'b0, x);
        chk("csum_model", {24'b0, x}, 32'h44);
        send_byte(8'h44, 0);
        chk("csum_ok_done", {31'b0, o_done}, 32'd1);
        chk("csum_ok_hold", {31'b0, o_cpu_hold}, 32'd0);
        we0 = n_we; d0 = n_done;
        load_body(1, 0, 1'b0, x);
        send_byte(8'h45, 0);
        chk("csum_bad_err", {31'b0, o_err}, 32'd1);
        chk("csum_bad_hold", {31'b0, o_cpu_hold}, 32'd1);
        chk("csum_bad_done", {31'b0, o_done}, 32'd0);
        repeat (3) @(negedge i_clk);
        chk("csum_bad_written", n_we - we0, 32'd1);
        chk("csum_bad_no_done", n_done - d0, 32'd0);
`endif

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
